// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//   Selects one ALU unit result by opcode, derives zero/overflow/illegal flags,
//   and registers the bundle behind a valid/ready handshake. A two-entry
//   (output + skid) buffer gives full throughput with in_ready depending only
//   on registered state and reset.
//
//   Optional feature macro: ALU_RESULT_PARITY_EN
//     When defined, adds out_parity = XOR-reduction of result, computed on the
//     input side and stored with each bundle.
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] and_res,
    input  logic [WIDTH-1:0] or_res,
    input  logic [WIDTH-1:0] xor_res,
    input  logic [WIDTH-1:0] nor_res,
    input  logic [WIDTH-1:0] add_res,
    input  logic [WIDTH-1:0] sub_res,
    input  logic [WIDTH-1:0] slt_res,
    input  logic             add_ovf,
    input  logic             sub_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal_op
`ifdef ALU_RESULT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    // One result bundle: data and flags always travel together.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             overflow;
        logic             illegal;
`ifdef ALU_RESULT_PARITY_EN
        logic             parity;
`endif
    } bundle_t;

    bundle_t in_bundle;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    accept;
    logic    present;

    // Opcode select and flag derivation for the incoming bundle.
    always_comb begin
        // NOTE: every variable written in this block gets a default first, so
        // no path through the case can leave it unassigned and infer a latch.
        in_bundle = '0;
        unique case (alu_op)
            3'b000: in_bundle.result = and_res;
            3'b001: in_bundle.result = or_res;
            3'b010: in_bundle.result = xor_res;
            3'b011: in_bundle.result = nor_res;
            3'b100: begin
                in_bundle.result   = add_res;
                in_bundle.overflow = add_ovf;
            end
            3'b101: begin
                in_bundle.result   = sub_res;
                in_bundle.overflow = sub_ovf;
            end
            3'b110: in_bundle.result = slt_res;
            default: in_bundle.illegal = 1'b1;
        endcase
        in_bundle.zero = (in_bundle.result == '0);
`ifdef ALU_RESULT_PARITY_EN
        in_bundle.parity = ^in_bundle.result;
`endif
    end

    // The skid entry is only ever full when the output entry is, so a free
    // skid slot is exactly "room for one more".
    assign in_ready = rst_n & ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign present  = out_valid_q & out_ready;

    // Next-state of the two-entry buffer; SKID always drains before new input.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || present) begin
            if (skid_valid_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                if (accept) begin
                    skid_d = in_bundle;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (accept) begin
                out_d       = in_bundle;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_bundle;
            skid_valid_d = 1'b1;
        end
    end

    // Output entry and occupancy flags, synchronously cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Skid payload register.
    always_ff @(posedge clk) begin
        // NOTE: the skid payload is deliberately not reset; skid_valid_q gates
        // it, so its contents are never observed while the entry is empty.
        skid_q <= skid_d;
    end

    assign out_valid  = out_valid_q;
    assign result     = out_q.result;
    assign zero       = out_q.zero;
    assign overflow   = out_q.overflow;
    assign illegal_op = out_q.illegal;
`ifdef ALU_RESULT_PARITY_EN
    assign out_parity = out_q.parity;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_result_stage
//   Self-checking bench: a queue-based reference model (capacity 2, FIFO)
//   predicts every output on every cycle; directed sequences add literal
//   expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_result_stage;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             overflow;
        logic             illegal;
        logic             parity;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       alu_op = 3'b000;
    logic [WIDTH-1:0] and_res = '0, or_res = '0, xor_res = '0, nor_res = '0;
    logic [WIDTH-1:0] add_res = '0, sub_res = '0, slt_res = '0;
    logic             add_ovf = 1'b0, sub_ovf = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zero, overflow, illegal_op;
`ifdef ALU_RESULT_PARITY_EN
    logic             out_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .and_res    (and_res),
        .or_res     (or_res),
        .xor_res    (xor_res),
        .nor_res    (nor_res),
        .add_res    (add_res),
        .sub_res    (sub_res),
        .slt_res    (slt_res),
        .add_ovf    (add_ovf),
        .sub_ovf    (sub_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .illegal_op (illegal_op)
`ifdef ALU_RESULT_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What the stage must produce for the bundle currently on its inputs.
    function automatic exp_t expected_bundle();
        exp_t e;
        e = '0;
        case (alu_op)
            3'd0: e.result = and_res;
            3'd1: e.result = or_res;
            3'd2: e.result = xor_res;
            3'd3: e.result = nor_res;
            3'd4: begin e.result = add_res; e.overflow = add_ovf; end
            3'd5: begin e.result = sub_res; e.overflow = sub_ovf; end
            3'd6: e.result = slt_res;
            default: e.illegal = 1'b1;
        endcase
        e.zero   = (e.result == 0);
        e.parity = ^e.result;
        return e;
    endfunction

    // Reference model: a FIFO of at most two bundles; "hold" is what the
    // output register shows once the FIFO has drained.
    exp_t model_q[$];
    exp_t hold = '0;

    always @(posedge clk) begin
        bit acc, pres;
        if (!rst_n) begin
            model_q.delete();
            hold = '0;
        end else begin
            acc  = in_valid && (model_q.size() < 2);
            pres = (model_q.size() > 0) && out_ready;
            if (pres) hold = model_q.pop_front();
            if (acc)  model_q.push_back(expected_bundle());
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        e = (model_q.size() > 0) ? model_q[0] : hold;
        check("in_ready",  {63'd0, in_ready},  {63'd0, (rst_n && model_q.size() < 2)});
        check("out_valid", {63'd0, out_valid}, {63'd0, (model_q.size() > 0)});
        check("result",    {32'd0, result},    {32'd0, e.result});
        check("zero",      {63'd0, zero},      {63'd0, e.zero});
        check("overflow",  {63'd0, overflow},  {63'd0, e.overflow});
        check("illegal",   {63'd0, illegal_op},{63'd0, e.illegal});
`ifdef ALU_RESULT_PARITY_EN
        check("parity",    {63'd0, out_parity},{63'd0, e.parity});
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_units(input logic [WIDTH-1:0] v);
        and_res = v; or_res = v; xor_res = v; nor_res = v;
        add_res = v; sub_res = v; slt_res = v;
    endtask

    task automatic rand_units();
        and_res = $urandom; or_res = $urandom; xor_res = $urandom;
        nor_res = $urandom; add_res = $urandom; sub_res = $urandom;
        slt_res = {31'd0, 1'($urandom_range(0, 1))};
        add_ovf = 1'($urandom_range(0, 1));
        sub_ovf = 1'($urandom_range(0, 1));
        // Occasionally force a zero result to exercise the zero flag.
        if ($urandom_range(0, 7) == 0) set_units('0);
    endtask

    initial begin
        // Reset held for two cycles.
        rst_n = 1'b0;
        step(); step();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd0);

        // Release and select NOR with a zero result.
        rst_n = 1'b1;
        alu_op = 3'b011; nor_res = '0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("in_ready_after_release", {63'd0, in_ready}, 64'd1);
        step();
        check("nor_valid",   {63'd0, out_valid}, 64'd1);
        check("nor_result",  {32'd0, result},    64'd0);
        check("nor_zero",    {63'd0, zero},      64'd1);
        check("nor_ovf",     {63'd0, overflow},  64'd0);
        check("nor_illegal", {63'd0, illegal_op},64'd0);

        // ADD overflow routing.
        alu_op = 3'b100; add_res = 32'h8000_0000; add_ovf = 1'b1; sub_ovf = 1'b0;
        step();
        check("add_result", {32'd0, result},   64'h8000_0000);
        check("add_ovf",    {63'd0, overflow}, 64'd1);
        check("add_zero",   {63'd0, zero},     64'd0);
        alu_op = 3'b011; nor_res = 32'h5;
        step();
        check("nor_ignores_add_ovf", {63'd0, overflow}, 64'd0);

        // Illegal op.
        alu_op = 3'b111; set_units(32'hFFFF_FFFF);
        step();
        check("ill_result", {32'd0, result},     64'd0);
        check("ill_zero",   {63'd0, zero},       64'd1);
        check("ill_flag",   {63'd0, illegal_op}, 64'd1);

        // Drain, then backpressure and skid.
        in_valid = 1'b0; add_ovf = 1'b0;
        step();
        out_ready = 1'b0; in_valid = 1'b1;
        alu_op = 3'b000; and_res = 32'h1234;
        step();
        check("bp_a_result", {32'd0, result}, 64'h1234);
        alu_op = 3'b001; or_res = 32'h00FF;
        step();
        check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_hold_a",        {32'd0, result},   64'h1234);
        alu_op = 3'b010; xor_res = 32'hAAAA;
        step();
        check("bp_third_ignored", {32'd0, result},   64'h1234);
        check("bp_still_full",    {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_b_result",    {32'd0, result},    64'h00FF);
        check("bp_b_valid",     {63'd0, out_valid}, 64'd1);
        check("bp_ready_back",  {63'd0, in_ready},  64'd1);
        step();
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // Streaming: eight back-to-back bundles, no bubbles.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alu_op = (i < 7) ? 3'(i) : 3'b000;
            rand_units();
            step();
            check("stream_valid", {63'd0, out_valid}, 64'd1);
            check("stream_ready", {63'd0, in_ready},  64'd1);
        end

        // Reset mid-operation with both entries full.
        out_ready = 1'b0; in_valid = 1'b1;
        rand_units(); step();
        rand_units(); step();
        check("mid_full", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready},  64'd1);
        out_ready = 1'b1;
        step();
        check("mid_no_stale", {63'd0, out_valid}, 64'd0);

`ifdef ALU_RESULT_PARITY_EN
        alu_op = 3'b000; and_res = 32'h0000_0007; in_valid = 1'b1;
        step();
        check("parity_7", {63'd0, out_parity}, 64'd1);
        in_valid = 1'b0;
        step();
`endif

        // Randomized phase with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            alu_op    = 3'($urandom_range(0, 7));
            rand_units();
            step();
        end

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
